mem_arbiter_responder: RTL and testbench

//  Responder for the pipeline's two memory ports (i_mem_*, d_mem_*). Arbitrates both onto one

---
 rtl/mem_arbiter_responder.sv | 122 ++++++++++++
 tb/tb_mem_arbiter_responder.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter_responder.sv
// rtl/mem_arbiter_responder.sv - arbitrates the i/d memory ports onto one physical memory port
module mem_arbiter_responder #(
    parameter logic D_PRIORITY = 1'b1
) (
    input  logic        clk,
    input  logic        reset,

    input  logic        i_mem_read,
    input  logic        i_mem_write,
    input  logic [15:0] i_mem_address,
    input  logic [15:0] i_mem_wdata,
    input  logic [1:0]  i_mem_byte_enable,
    output logic        i_mem_resp,
    output logic [15:0] i_mem_rdata,

    input  logic        d_mem_read,
    input  logic        d_mem_write,
    input  logic [15:0] d_mem_address,
    input  logic [15:0] d_mem_wdata,
    input  logic [1:0]  d_mem_byte_enable,
    output logic        d_mem_resp,
    output logic [15:0] d_mem_rdata,

    output logic        pmem_read,
    output logic        pmem_write,
    output logic [15:0] pmem_address,
    output logic [15:0] pmem_wdata,
    output logic [1:0]  pmem_byte_enable,
    input  logic        pmem_resp,
    input  logic [15:0] pmem_rdata
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        I_ACC  = 3'd1,
        D_ACC  = 3'd2,
        I_RESP = 3'd3,
        D_RESP = 3'd4
    } state_t;

    state_t state;
    logic   last_grant_d;
    logic   req_i;
    logic   req_d;
    logic   grant_d;

    // On a tie the d-port wins outright, or in round-robin mode the port not served last wins.
    always_comb begin
        req_i   = i_mem_read | i_mem_write;
        req_d   = d_mem_read | d_mem_write;
        grant_d = 1'b0;
        if (req_d && !req_i)
            grant_d = 1'b1;
        else if (req_d && req_i)
            grant_d = D_PRIORITY | ~last_grant_d;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state            <= IDLE;
            last_grant_d     <= 1'b0;
            i_mem_resp       <= 1'b0;
            i_mem_rdata      <= 16'h0000;
            d_mem_resp       <= 1'b0;
            d_mem_rdata      <= 16'h0000;
            pmem_read        <= 1'b0;
            pmem_write       <= 1'b0;
            pmem_address     <= 16'h0000;
            pmem_wdata       <= 16'h0000;
            pmem_byte_enable <= 2'b00;
        end else begin
            i_mem_resp  <= 1'b0;
            i_mem_rdata <= 16'h0000;
            d_mem_resp  <= 1'b0;
            d_mem_rdata <= 16'h0000;
            case (state)
                IDLE: begin
                    if (grant_d) begin
                        state            <= D_ACC;
                        pmem_read        <= d_mem_read;
                        pmem_write       <= d_mem_write & ~d_mem_read;
                        pmem_address     <= d_mem_address;
                        pmem_wdata       <= d_mem_wdata;
                        pmem_byte_enable <= d_mem_byte_enable;
                    end else if (req_i) begin
                        state            <= I_ACC;
                        pmem_read        <= i_mem_read;
                        pmem_write       <= i_mem_write & ~i_mem_read;
                        pmem_address     <= i_mem_address;
                        pmem_wdata       <= i_mem_wdata;
                        pmem_byte_enable <= i_mem_byte_enable;
                    end
                end
                // The transaction completes even if the requester drops its request meanwhile.
                I_ACC: begin
                    if (pmem_resp) begin
                        state        <= I_RESP;
                        pmem_read    <= 1'b0;
                        pmem_write   <= 1'b0;
                        i_mem_resp   <= 1'b1;
                        i_mem_rdata  <= pmem_rdata;
                        last_grant_d <= 1'b0;
                    end
                end
                D_ACC: begin
                    if (pmem_resp) begin
                        state        <= D_RESP;
                        pmem_read    <= 1'b0;
                        pmem_write   <= 1'b0;
                        d_mem_resp   <= 1'b1;
                        d_mem_rdata  <= pmem_rdata;
                        last_grant_d <= 1'b1;
                    end
                end
                I_RESP:  state <= IDLE;
                D_RESP:  state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter_responder.sv
// tb/tb_mem_arbiter_responder.sv - directed self-checking bench for mem_arbiter_responder
module tb_mem_arbiter_responder;

    logic        clk = 1'b0;
    logic        reset;
    logic        i_mem_read, i_mem_write, d_mem_read, d_mem_write;
    logic [15:0] i_mem_address, i_mem_wdata, d_mem_address, d_mem_wdata;
    logic [1:0]  i_mem_byte_enable, d_mem_byte_enable;
    logic        pmem_resp;
    logic [15:0] pmem_rdata;

    logic        i_mem_resp, d_mem_resp, pmem_read, pmem_write;
    logic [15:0] i_mem_rdata, d_mem_rdata, pmem_address, pmem_wdata;
    logic [1:0]  pmem_byte_enable;

    logic        rr_i_mem_resp, rr_d_mem_resp, rr_pmem_read, rr_pmem_write;
    logic [15:0] rr_i_mem_rdata, rr_d_mem_rdata, rr_pmem_address, rr_pmem_wdata;
    logic [1:0]  rr_pmem_byte_enable;

    int n_checks = 0;
    int n_passed = 0;

    always #5 clk = ~clk;

    mem_arbiter_responder #(.D_PRIORITY(1'b1)) dut (
        .clk(clk), .reset(reset),
        .i_mem_read(i_mem_read), .i_mem_write(i_mem_write), .i_mem_address(i_mem_address),
        .i_mem_wdata(i_mem_wdata), .i_mem_byte_enable(i_mem_byte_enable),
        .i_mem_resp(i_mem_resp), .i_mem_rdata(i_mem_rdata),
        .d_mem_read(d_mem_read), .d_mem_write(d_mem_write), .d_mem_address(d_mem_address),
        .d_mem_wdata(d_mem_wdata), .d_mem_byte_enable(d_mem_byte_enable),
        .d_mem_resp(d_mem_resp), .d_mem_rdata(d_mem_rdata),
        .pmem_read(pmem_read), .pmem_write(pmem_write), .pmem_address(pmem_address),
        .pmem_wdata(pmem_wdata), .pmem_byte_enable(pmem_byte_enable),
        .pmem_resp(pmem_resp), .pmem_rdata(pmem_rdata)
    );

    mem_arbiter_responder #(.D_PRIORITY(1'b0)) dut_rr (
        .clk(clk), .reset(reset),
        .i_mem_read(i_mem_read), .i_mem_write(i_mem_write), .i_mem_address(i_mem_address),
        .i_mem_wdata(i_mem_wdata), .i_mem_byte_enable(i_mem_byte_enable),
        .i_mem_resp(rr_i_mem_resp), .i_mem_rdata(rr_i_mem_rdata),
        .d_mem_read(d_mem_read), .d_mem_write(d_mem_write), .d_mem_address(d_mem_address),
        .d_mem_wdata(d_mem_wdata), .d_mem_byte_enable(d_mem_byte_enable),
        .d_mem_resp(rr_d_mem_resp), .d_mem_rdata(rr_d_mem_rdata),
        .pmem_read(rr_pmem_read), .pmem_write(rr_pmem_write), .pmem_address(rr_pmem_address),
        .pmem_wdata(rr_pmem_wdata), .pmem_byte_enable(rr_pmem_byte_enable),
        .pmem_resp(pmem_resp), .pmem_rdata(pmem_rdata)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp)
            n_passed++;
        else
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        reset = 1'b0;
    endtask

    logic [15:0] zw_addr [3];
    logic        grant_d_seen [$];
    int          n_grants;

    initial begin
        reset = 1'b1;
        i_mem_read = 0; i_mem_write = 0; i_mem_address = 0; i_mem_wdata = 0; i_mem_byte_enable = 0;
        d_mem_read = 0; d_mem_write = 0; d_mem_address = 0; d_mem_wdata = 0; d_mem_byte_enable = 0;
        pmem_resp = 0; pmem_rdata = 0;
        step();
        step();

        check("rst_i_resp", {31'd0, i_mem_resp}, 0);
        check("rst_d_resp", {31'd0, d_mem_resp}, 0);
        check("rst_strobes", {30'd0, pmem_read, pmem_write}, 0);
        check("rst_addr", {16'd0, pmem_address}, 0);
        check("rst_wdata_be", {14'd0, pmem_wdata, pmem_byte_enable}, 0);
        reset = 1'b0;

        // i-read 0x3000, memory answers two cycles after the strobe
        i_mem_read = 1; i_mem_address = 16'h3000; i_mem_byte_enable = 2'b11;
        step();
        check("t1_strobe", {31'd0, pmem_read}, 1);
        check("t1_addr", {16'd0, pmem_address}, 32'h3000);
        step();
        check("t1_wait_resp", {31'd0, i_mem_resp}, 0);
        check("t1_wait_strobe", {31'd0, pmem_read}, 1);
        step();
        pmem_resp = 1; pmem_rdata = 16'h1234;
        step();
        pmem_resp = 0;
        check("t1_resp", {31'd0, i_mem_resp}, 1);
        check("t1_rdata", {16'd0, i_mem_rdata}, 32'h1234);
        check("t1_strobe_drop", {31'd0, pmem_read}, 0);
        check("t1_no_d_resp", {31'd0, d_mem_resp}, 0);
        i_mem_read = 0;
        step();
        check("t1_one_pulse", {31'd0, i_mem_resp}, 0);

        // d-write with high-byte enable
        d_mem_write = 1; d_mem_address = 16'h4002; d_mem_wdata = 16'hBEEF; d_mem_byte_enable = 2'b10;
        step();
        check("t2_write", {30'd0, pmem_read, pmem_write}, 32'b01);
        check("t2_addr", {16'd0, pmem_address}, 32'h4002);
        check("t2_wdata", {16'd0, pmem_wdata}, 32'hBEEF);
        check("t2_be", {30'd0, pmem_byte_enable}, 32'b10);
        pmem_resp = 1;
        step();
        pmem_resp = 0;
        check("t2_resp", {31'd0, d_mem_resp}, 1);
        check("t2_no_i_resp", {31'd0, i_mem_resp}, 0);
        d_mem_write = 0;
        step();
        check("t2_one_pulse", {31'd0, d_mem_resp}, 0);

        // simultaneous requests: d first, then i
        i_mem_read = 1; i_mem_address = 16'h1000;
        d_mem_read = 1; d_mem_address = 16'h2000; d_mem_byte_enable = 2'b11;
        step();
        check("t3_d_first", {16'd0, pmem_address}, 32'h2000);
        pmem_resp = 1; pmem_rdata = 16'hD00D;
        step();
        pmem_resp = 0;
        check("t3_resps_d", {30'd0, i_mem_resp, d_mem_resp}, 32'b01);
        check("t3_d_rdata", {16'd0, d_mem_rdata}, 32'hD00D);
        d_mem_read = 0;
        step();
        check("t3_idle_gap", {30'd0, pmem_read, i_mem_resp}, 0);
        step();
        check("t3_i_second", {15'd0, pmem_read, pmem_address}, 32'h11000);
        pmem_resp = 1; pmem_rdata = 16'h1111;
        step();
        pmem_resp = 0;
        check("t3_resps_i", {30'd0, i_mem_resp, d_mem_resp}, 32'b10);
        check("t3_i_rdata", {16'd0, i_mem_rdata}, 32'h1111);
        i_mem_read = 0;
        step();

        // reset while in D_ACC, then a stray pmem_resp
        d_mem_read = 1; d_mem_address = 16'h5000;
        step();
        check("t4_in_acc", {31'd0, pmem_read}, 1);
        reset = 1;
        step();
        reset = 0; d_mem_read = 0;
        check("t4_strobe_off", {30'd0, pmem_read, pmem_write}, 0);
        check("t4_addr_clr", {16'd0, pmem_address}, 0);
        pmem_resp = 1; pmem_rdata = 16'hDEAD;
        step();
        check("t4_stray_resp", {30'd0, i_mem_resp, d_mem_resp}, 0);
        check("t4_still_idle", {31'd0, pmem_read}, 0);
        step();
        check("t4_stray_resp2", {30'd0, i_mem_resp, d_mem_resp}, 0);
        pmem_resp = 0;

        // zero-wait memory, back-to-back i-reads: one resp every 3 cycles
        zw_addr[0] = 16'h0100; zw_addr[1] = 16'h0102; zw_addr[2] = 16'h0104;
        pmem_resp = 1;
        i_mem_read = 1; i_mem_address = zw_addr[0];
        for (int k = 0; k < 3; k++) begin
            step();
            check("t5_addr", {15'd0, pmem_read, pmem_address}, {15'd0, 1'b1, zw_addr[k]});
            pmem_rdata = 16'hC000 + 16'(k);
            step();
            check("t5_resp", {31'd0, i_mem_resp}, 1);
            check("t5_rdata", {16'd0, i_mem_rdata}, 32'hC000 + k);
            if (k < 2) i_mem_address = zw_addr[k+1];
            else i_mem_read = 0;
            step();
            check("t5_gap", {31'd0, i_mem_resp}, 0);
        end
        pmem_resp = 0;

        // round-robin instance, both ports held, zero-wait memory
        do_reset();
        i_mem_read = 1; i_mem_address = 16'h0AAA;
        d_mem_read = 1; d_mem_address = 16'h0DDD;
        pmem_resp = 1;
        for (int c = 0; c < 12; c++) begin
            step();
            if (rr_pmem_read) grant_d_seen.push_back(rr_pmem_address == 16'h0DDD);
            if (rr_i_mem_resp && rr_d_mem_resp) check("t6_both_resp", 1, 0);
        end
        n_grants = grant_d_seen.size();
        check("t6_grant_count", n_grants, 4);
        for (int j = 0; j < n_grants && j < 4; j++)
            check("t6_grant_order", {31'd0, grant_d_seen[j]}, {31'd0, (j % 2) == 0});
        i_mem_read = 0; d_mem_read = 0; pmem_resp = 0;
        do_reset();

        $display("%0d/%0d checks passed", n_passed, n_checks);
        $finish;
    end

endmodule
